// File: rtl/axi4_pkg.sv
// axi4_pkg: shared types and constants for the AXI4 subordinate memory.
// Holds the write/read FSM state encodings, BRESP codes and beat-counter width.
package axi4_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi4_sub_mem_array.sv
// axi4_sub_mem_array: MEM_WORDS x 32 storage, byte-enabled write, async read.
// Ports: clk; we/waddr/wdata/wstrb write port; raddr -> rdata read port.
module axi4_sub_mem_array
    import axi4_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    // No reset: contents survive rst_n.
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_subordinate_mem.sv
// axi4_subordinate_mem: AXI4 INCR-burst subordinate over a word memory.
// Ports: clk, rst_n; AW/W/B write channels; AR/R read channels.
module axi4_subordinate_mem
    import axi4_pkg::*;
#(
    parameter int ADDRWIDTH    = 32,
    parameter int DATAWIDTH    = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDRWIDTH-1:0] awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [2:0]           awprot,
    input  logic [7:0]           awlen,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic                 wlast,
    input  logic [3:0]           wstrb,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    input  logic [ADDRWIDTH-1:0] araddr,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [2:0]           arprot,
    input  logic [7:0]           arlen,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 rlast
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [IDX_W-1:0] IDX_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [3:0]       WAIT_ONE  = 1;
    // Unreachable when READ_LATENCY is 0 (R_WAIT is skipped).
    localparam logic [3:0]       WAIT_LAST = 4'(READ_LATENCY - 1);

    w_state_t         w_state, w_next;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W-1:0] w_len, w_cnt;
    logic             w_err, w_last_beat, beat_err, mem_we;

    r_state_t         r_state, r_next;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_len, r_cnt;
    logic [3:0]       r_wait;
    logic             r_last_beat;

    logic unused;
    assign unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0],
                      awaddr[ADDRWIDTH-1:IDX_W+2],
                      araddr[ADDRWIDTH-1:IDX_W+2]};

    assign w_last_beat = (w_cnt == w_len);
    // wlast must be high exactly on the final beat; anything else is sticky.
    assign beat_err    = w_err | (wlast != w_last_beat);
    assign r_last_beat = (r_cnt == r_len);

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        mem_we  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = 1'b1;
                    if (w_last_beat) w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bresp   <= BRESP_OKAY;
        end else begin
            w_state <= w_next;
            if (awvalid && awready) begin
                w_idx <= awaddr[IDX_W+1:2];
                w_len <= awlen;
                w_cnt <= '0;
                w_err <= 1'b0;
            end
            if (mem_we) begin
                w_idx <= w_idx + IDX_ONE;
                w_cnt <= w_cnt + CNT_ONE;
                w_err <= beat_err;
                if (w_last_beat) begin
                    bresp <= beat_err ? BRESP_SLVERR : BRESP_OKAY;
                end
            end
        end
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_next = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_wait == WAIT_LAST) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = r_last_beat;
                if (rready && r_last_beat) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= r_next;
            if (arvalid && arready) begin
                r_idx  <= araddr[IDX_W+1:2];
                r_len  <= arlen;
                r_cnt  <= '0;
                r_wait <= '0;
            end
            if (r_state == R_WAIT) begin
                r_wait <= r_wait + WAIT_ONE;
            end
            if (rvalid && rready && !r_last_beat) begin
                r_idx <= r_idx + IDX_ONE;
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    axi4_sub_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_idx),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (r_idx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_axi4_subordinate_mem.sv
// tb_axi4_subordinate_mem: table-driven bench with a read/response scoreboard.
// Drives and samples on the falling clock edge.
module tb_axi4_subordinate_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [2:0]  awprot = '0;
    logic [7:0]  awlen = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        wlast = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [2:0]  arprot = '0;
    logic [7:0]  arlen = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        rlast;

    always #5 clk = ~clk;

    axi4_subordinate_mem dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .awprot  (awprot),
        .awlen   (awlen),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .wlast   (wlast),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .arprot  (arprot),
        .arlen   (arlen),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .rlast   (rlast)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [31:0] base;
        logic [3:0]  strb;
        int          stall_beat;
        int          stall_cyc;
        logic [31:0] exp0;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [1024];
    logic [31:0] rd_q [$];
    logic        rl_q [$];
    logic [1:0]  b_q  [$];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic        lbuf [16];
    vec_t        vt   [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len,
                             input int bdelay);
        int          n;
        logic [9:0]  idx;
        logic        err;
        logic [31:0] m;
        logic [1:0]  eb;
        err = 1'b0;
        for (int i = 0; i <= len; i++)
            if (lbuf[i] != (i == len)) err = 1'b1;
        b_q.push_back(err ? 2'b10 : 2'b00);
        awaddr  = addr;
        awlen   = 8'(len);
        awvalid = 1'b1;
        wdata   = wbuf[0];
        wstrb   = sbuf[0];
        wlast   = lbuf[0];
        wvalid  = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", awready, 1);
        check("wready_during_aw", wready, 0);
        @(negedge clk);
        awvalid = 1'b0;
        idx = addr[11:2];
        for (int i = 0; i <= len; i++) begin
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = lbuf[i];
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) begin
                check("w_timeout", wready, 1);
                wvalid = 1'b0;
                void'(b_q.pop_front());
                return;
            end
            m = model[idx];
            for (int b = 0; b < 4; b++)
                if (sbuf[i][b]) m[8*b +: 8] = wbuf[i][8*b +: 8];
            model[idx] = m;
            @(negedge clk);
            idx++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) begin
            check("b_timeout", bvalid, 1);
            void'(b_q.pop_front());
            return;
        end
        for (int d = 0; d < bdelay; d++) begin
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, b_q[0]);
            @(negedge clk);
        end
        bready = 1'b1;
        eb = b_q.pop_front();
        check("bresp", bresp, eb);
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len,
                            input int stall_beat, input int stall_cyc,
                            output logic [31:0] first);
        int          n;
        logic [9:0]  idx;
        logic [31:0] e;
        logic        el;
        first = 'x;
        idx = addr[11:2];
        for (int i = 0; i <= len; i++) begin
            rd_q.push_back(model[idx]);
            rl_q.push_back(i == len);
            idx++;
        end
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (!rvalid) begin
                check("r_timeout", rvalid, 1);
                rd_q.delete();
                rl_q.delete();
                return;
            end
            if (i == 0) check("read_latency", n, 0);
            if (i == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    check("stall_rvalid", rvalid, 1);
                    check("stall_rdata", rdata, rd_q[0]);
                    check("stall_rlast", rlast, rl_q[0]);
                    @(negedge clk);
                end
                rready = 1'b1;
            end
            e  = rd_q.pop_front();
            el = rl_q.pop_front();
            if (i == 0) first = rdata;
            check("rdata", rdata, e);
            check("rlast", rlast, el);
            @(negedge clk);
        end
        rready = 1'b0;
        check("arready_after_read", arready, 1);
    endtask

    task automatic fill(input int len, input logic [31:0] base,
                        input logic [3:0] strb);
        for (int i = 0; i <= len; i++) begin
            wbuf[i] = base + 32'(i);
            sbuf[i] = strb;
            lbuf[i] = (i == len);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] first;
        for (int i = 0; i < 1024; i++) model[i] = '0;

        vt[0] = '{32'h010, 0, 32'hDEADBEEF, 4'hF, -1, 0, 32'hDEADBEEF};
        vt[1] = '{32'h100, 3, 32'h00000001, 4'hF,  1, 3, 32'h00000001};
        vt[2] = '{32'h200, 0, 32'hFFFFFFFF, 4'hF, -1, 0, 32'hFFFFFFFF};
        vt[3] = '{32'h200, 0, 32'h00000000, 4'h5, -1, 0, 32'hFF00FF00};
        vt[4] = '{32'hFFC, 1, 32'hA5A50000, 4'hF,  0, 2, 32'hA5A50000};
        vt[5] = '{32'h000, 0, 32'h12345678, 4'h0, -1, 0, 32'hA5A50001};
        vt[6] = '{32'h010, 0, 32'h00000000, 4'hA, -1, 0, 32'h00AD00EF};
        vt[7] = '{32'h303, 2, 32'h00000030, 4'hF,  2, 1, 32'h00000030};

        repeat (3) @(negedge clk);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fill(vt[v].len, vt[v].base, vt[v].strb);
            axi_write(vt[v].addr, vt[v].len, v % 3);
            axi_read(vt[v].addr, vt[v].len,
                     vt[v].stall_beat, vt[v].stall_cyc, first);
            check("vec_exp0", first, vt[v].exp0);
        end

        // wlast early on beat 2 of 3: all beats still land, SLVERR.
        fill(2, 32'h50, 4'hF);
        lbuf[0] = 1'b0; lbuf[1] = 1'b1; lbuf[2] = 1'b0;
        axi_write(32'h500, 2, 2);
        axi_read(32'h500, 2, -1, 0, first);
        check("early_wlast_b0", first, 32'h50);

        // wlast never asserted.
        fill(1, 32'h60, 4'hF);
        lbuf[1] = 1'b0;
        axi_write(32'h600, 1, 0);

        // Error flag must not leak into the next burst.
        fill(0, 32'h70, 4'hF);
        axi_write(32'h700, 0, 1);
        axi_read(32'h700, 0, -1, 0, first);

        // Reset mid-read of an 8-beat burst.
        fill(7, 32'h400, 4'hF);
        axi_write(32'h400, 7, 0);
        araddr  = 32'h400;
        arlen   = 8'd7;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("pre_rst_rdata", rdata, 32'h400 + 32'(i));
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rlast", rlast, 0);
        check("midrst_arready", arready, 1);
        check("midrst_awready", awready, 1);
        check("midrst_wready", wready, 0);
        @(negedge clk);
        rready = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("postrst_arready", arready, 1);
        check("postrst_rvalid", rvalid, 0);
        axi_read(32'h400, 7, 4, 2, first);
        check("mem_persist", first, 32'h400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_subordinate_mem.md
AXI4_SUBORDINATE_MEM -- requirements
Module: axi4_subordinate_mem
Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 32: byte address width; only value supported.
REQ-002 SHALL have parameter DATAWIDTH, default 32: data width; only value supported.
REQ-003 SHALL have parameter MEM_WORDS, default 1024: 32-bit memory depth; power of 2, from 2 to 65536.
REQ-004 SHALL have parameter READ_LATENCY, default 0: idle cycles between AR accept and first rvalid; 0 to 15.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port awaddr, input, ADDRWIDTH: write burst start byte address.
REQ-008 SHALL have port awvalid, input, 1: write address valid.
REQ-009 SHALL have port awready, output, 1: write address accepted.
REQ-010 SHALL have port awprot, input, 3: ignored.
REQ-011 SHALL have port awlen, input, 8: write beats minus 1.
REQ-012 SHALL have port wdata, input, DATAWIDTH: write data.
REQ-013 SHALL have port wvalid, input, 1: write data valid.
REQ-014 SHALL have port wready, output, 1: write data accepted.
REQ-015 SHALL have port wlast, input, 1: final write beat.
REQ-016 SHALL have port wstrb, input, 4: byte lane enables.
REQ-017 SHALL have port bvalid, output, 1: write response valid.
REQ-018 SHALL have port bready, input, 1: write response accepted.
REQ-019 SHALL have port bresp, output, 2: 2'b00 OKAY or 2'b10 SLVERR.
REQ-020 SHALL have port araddr, input, ADDRWIDTH: read burst start byte address.
REQ-021 SHALL have port arvalid, input, 1: read address valid.
REQ-022 SHALL have port arready, output, 1: read address accepted.
REQ-023 SHALL have port arprot, input, 3: ignored.
REQ-024 SHALL have port arlen, input, 8: read beats minus 1.
REQ-025 SHALL have port rdata, output, DATAWIDTH: read data.
REQ-026 SHALL have port rvalid, output, 1: read data valid.
REQ-027 SHALL have port rready, input, 1: read data accepted.
REQ-028 SHALL have port rlast, output, 1: final read beat.
Function
REQ-029 SHALL implement INCR bursts only; word index = addr[ADDRWIDTH-1:2] mod MEM_WORDS; addr[1:0] ignored; index wraps to 0 past MEM_WORDS-1, both mid-burst and at start.
REQ-030 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP: awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-031 W_IDLE SHALL go to W_DATA on awvalid&awready, latching the start index and awlen; W_DATA SHALL write on each wvalid&wready, then increment the index and the beat count.
REQ-032 W_DATA SHALL go to W_RESP after beat awlen+1; wlast SHALL NOT end the burst; bresp SHALL be SLVERR if wlast is wrong on any beat (early or missing on final), else OKAY.
REQ-033 Each write beat SHALL update only the byte lanes whose wstrb bit is 1; wstrb=0 SHALL be an accepted beat with no memory change.
REQ-034 W_RESP SHALL hold bvalid and bresp stable until bready, then go to W_IDLE; the next AW SHALL be accepted no sooner than the cycle after that handshake.
REQ-035 Read FSM SHALL use states R_IDLE, R_WAIT, R_DATA: arready=1 only in R_IDLE; on accept it SHALL latch the index and arlen, then enter R_WAIT for READ_LATENCY cycles, or R_DATA directly if READ_LATENCY=0.
REQ-036 In R_DATA, rvalid SHALL be 1; rdata = memory[index] via a combinational read; rlast=1 on beat arlen+1 only; on rvalid&rready it SHALL advance; after the last beat it SHALL go to R_IDLE.
REQ-037 While rvalid&~rready, rdata, rlast and the index SHALL hold; a write to the current read word becomes visible on rdata the cycle after its write edge.
REQ-038 Read and write FSMs SHALL run independently and concurrently; AW and W in the same cycle SHALL take two cycles (AW first, then W).
Reset
REQ-039 rst_n low SHALL immediately force both FSMs to idle: awready=1, arready=1, wready=0, bvalid=0, bresp=00, rvalid=0, rlast=0, all counters 0; a burst in flight SHALL be abandoned with no response.
REQ-040 Reset SHALL NOT clear memory; beats already written before reset SHALL persist.
Structure
REQ-041 Package axi4_pkg SHALL hold the FSM state enums, BRESP_OKAY/BRESP_SLVERR, and the beat-counter width (8).
REQ-042 The storage SHALL be sub-module axi4_sub_mem_array: MEM_WORDS x 32, one write port with 4 byte enables, one combinational read port.
Verification
REQ-043 Single write 0x00000010, data 0xDEADBEEF, wstrb F, awlen 0, then read 0x10 -> bresp 00, rdata 0xDEADBEEF, rlast=1.
REQ-044 Write 4 beats at 0x100, data 1..4, then arlen 3 read with rready low on beat 2 for 3 cycles -> rdata 1,2,3,4, with 2 held stable during the stall.
REQ-045 Write 0xFFFFFFFF, then write 0x00000000 with wstrb 0101 to the same word -> read returns 0xFF00FF00.
REQ-046 MEM_WORDS=1024, awlen 1, start 0xFFC (index 1023) -> second beat lands at index 0; read at 0x0 returns it.
REQ-047 awlen 2 with wlast on beat 2 -> 3 beats written, bresp 10; rst_n pulsed low mid-read of arlen 7 -> rvalid 0 immediately and arready 1 after release.
